acondicionador_botones: RTL and testbench

//  Front-end conditioner for the pet's four raw push buttons; sits directly upstream of Modos.

---
 rtl/acondicionador_botones_pkg.sv | 20 ++
 rtl/acondicionador_botones_canal.sv | 70 +++++++
 rtl/acondicionador_botones.sv | 63 ++++++
 tb/tb_acondicionador_botones.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/acondicionador_botones_pkg.sv
// Shared constants for the button conditioner: channel indices, default
// timing for a 50 MHz clock, and the counter width helper.
package acondicionador_botones_pkg;

    localparam int NUM_CH      = 4;
    localparam int CH_ENERGIA  = 0;
    localparam int CH_MEDICINA = 1;
    localparam int CH_TEST     = 2;
    localparam int CH_RESET    = 3;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DEB_CYC_DEF   = 1_000_000;
    localparam int LARGO_CYC_DEF = 250_000_000;

    // Counters must hold LARGO_CYC itself, since the long-press count saturates there.
    function automatic int cnt_width(input int largo_cyc);
        return $clog2(largo_cyc + 1);
    endfunction

endpackage

// File: rtl/acondicionador_botones_canal.sv
// One button channel: two-FF synchroniser, debounce, registered press pulse
// on the stable rising edge, and a single long-press pulse per hold.
module antirrebote_canal #(
    parameter int DEB_CYC   = 1_000_000,
    parameter int LARGO_CYC = 250_000_000,
    parameter int CNT_W     = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic boton_i,
    output logic est_o,
    output logic pulsa_o,
    output logic largo_o
);

    localparam logic [CNT_W-1:0] DEB_LIM   = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LARGO_MAX = CNT_W'(LARGO_CYC);
    localparam logic [CNT_W-1:0] LARGO_PRE = CNT_W'(LARGO_CYC - 2);

    logic             s1_q, s2_q;
    logic             est_q, est_d, est_prev_q;
    logic             pulsa_q, largo_q, largo_d;
    logic [CNT_W-1:0] cnt_deb_q, cnt_deb_d;
    logic [CNT_W-1:0] cnt_largo_q, cnt_largo_d;

    always_comb begin
        est_d       = est_q;
        cnt_deb_d   = '0;
        cnt_largo_d = '0;
        if (s2_q != est_q) begin
            if (cnt_deb_q == DEB_LIM) begin
                est_d = s2_q;
            end else begin
                cnt_deb_d = cnt_deb_q + CNT_W'(1);
            end
        end
        if (est_q) begin
            cnt_largo_d = (cnt_largo_q == LARGO_MAX) ? cnt_largo_q : cnt_largo_q + CNT_W'(1);
        end
        // Fire on the edge the count becomes LARGO_CYC-1; saturation keeps it one-shot.
        largo_d = est_q && (cnt_largo_q == LARGO_PRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            est_q       <= 1'b0;
            est_prev_q  <= 1'b0;
            pulsa_q     <= 1'b0;
            largo_q     <= 1'b0;
            cnt_deb_q   <= '0;
            cnt_largo_q <= '0;
        end else begin
            s1_q        <= boton_i;
            s2_q        <= s1_q;
            est_q       <= est_d;
            est_prev_q  <= est_q;
            pulsa_q     <= est_q & ~est_prev_q;
            largo_q     <= largo_d;
            cnt_deb_q   <= cnt_deb_d;
            cnt_largo_q <= cnt_largo_d;
        end
    end

    assign est_o   = est_q;
    assign pulsa_o = pulsa_q;
    assign largo_o = largo_q;

endmodule

// File: rtl/acondicionador_botones.sv
// Conditions the pet's four raw push buttons into clean pulses/levels for Modos:
// polarity fix, per-channel debounce, test-button toggle and output mapping.
module acondicionador_botones
    import acondicionador_botones_pkg::*;
#(
    parameter int DEB_CYC     = DEB_CYC_DEF,
    parameter int LARGO_CYC   = LARGO_CYC_DEF,
    parameter int ACTIVO_BAJO = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_energia_in,
    input  logic       btn_medicina_in,
    input  logic       btn_test_in,
    input  logic       btn_reset_in,
    output logic       Bot_Energia,
    output logic       Bot_Medicina,
    output logic       Bot_Test,
    output logic       Bot_Reset,
    output logic [3:0] estado_estable
);

    localparam int CNT_W = cnt_width(LARGO_CYC);

    logic [NUM_CH-1:0] raw, pres, est, pulsa, largo;
    logic              bot_test_q, bot_test_d;
    logic              unused_pulsos;

    assign raw  = {btn_reset_in, btn_test_in, btn_medicina_in, btn_energia_in};
    assign pres = (ACTIVO_BAJO != 0) ? ~raw : raw;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_canal
        antirrebote_canal #(
            .DEB_CYC  (DEB_CYC),
            .LARGO_CYC(LARGO_CYC),
            .CNT_W    (CNT_W)
        ) u_canal (
            .clk    (clk),
            .rst_n  (rst_n),
            .boton_i(pres[g]),
            .est_o  (est[g]),
            .pulsa_o(pulsa[g]),
            .largo_o(largo[g])
        );
    end

    assign bot_test_d = bot_test_q ^ largo[CH_TEST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bot_test_q <= 1'b0;
        else        bot_test_q <= bot_test_d;
    end

    // Short presses of test/reset and long presses of energia/medicina are intentionally dropped.
    assign unused_pulsos = ^{pulsa[CH_TEST], pulsa[CH_RESET], largo[CH_ENERGIA], largo[CH_MEDICINA]};

    assign Bot_Energia    = pulsa[CH_ENERGIA];
    assign Bot_Medicina   = pulsa[CH_MEDICINA];
    assign Bot_Test       = bot_test_q;
    assign Bot_Reset      = largo[CH_RESET];
    assign estado_estable = est;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Scoreboard bench: an event-timestamp model predicts pulse cycles and levels;
// a monitor on the falling edge compares the DUT against those predictions.
module tb_acondicionador_botones;
    import acondicionador_botones_pkg::*;

    localparam int DEB   = 4;
    localparam int LARGO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw = 4'hF;
    logic       Bot_Energia, Bot_Medicina, Bot_Test, Bot_Reset;
    logic [3:0] estado_estable;

    int n_chk = 0;
    int n_fail = 0;

    acondicionador_botones #(.DEB_CYC(DEB), .LARGO_CYC(LARGO), .ACTIVO_BAJO(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_energia_in (raw[0]),
        .btn_medicina_in(raw[1]),
        .btn_test_in    (raw[2]),
        .btn_reset_in   (raw[3]),
        .Bot_Energia    (Bot_Energia),
        .Bot_Medicina   (Bot_Medicina),
        .Bot_Test       (Bot_Test),
        .Bot_Reset      (Bot_Reset),
        .estado_estable (estado_estable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: timestamps of stable changes, pulses and toggles.
    int  cyc = 0;
    bit  s1m[4], s2m[4], estm[4];
    int  streak[4], rise[4];
    int  toggle_at = -1;
    bit  tlevel = 1'b0;
    int  expq[4][$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    s1m[i] = 0; s2m[i] = 0; estm[i] = 0; streak[i] = 0; rise[i] = 0;
                    expq[i].delete();
                end
                toggle_at = -1;
                tlevel    = 1'b0;
            end else begin
                cyc++;
                for (int i = 0; i < 4; i++) begin
                    if (estm[i] && cyc == rise[i] + LARGO - 1) begin
                        if (i == CH_RESET) expq[i].push_back(cyc);
                        if (i == CH_TEST)  toggle_at = cyc + 1;
                    end
                    if (s2m[i] != estm[i]) begin
                        streak[i]++;
                        if (streak[i] == DEB) begin
                            estm[i]   = s2m[i];
                            streak[i] = 0;
                            if (estm[i]) begin
                                rise[i] = cyc;
                                if (i == CH_ENERGIA || i == CH_MEDICINA) expq[i].push_back(cyc + 1);
                            end
                        end
                    end else begin
                        streak[i] = 0;
                    end
                    s2m[i] = s1m[i];
                    s1m[i] = ~raw[i];
                end
                if (cyc == toggle_at) tlevel = ~tlevel;
            end
        end
    end

    // Monitor
    initial begin
        logic [3:0] pv;
        logic [3:0] em;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", int'({estado_estable, Bot_Energia, Bot_Medicina, Bot_Test, Bot_Reset}), 0);
            end else begin
                em = {estm[3], estm[2], estm[1], estm[0]};
                chk("estado_estable", int'(estado_estable), int'(em));
                chk("bot_test_level", int'(Bot_Test), int'(tlevel));
                pv = {Bot_Reset, 1'b0, Bot_Medicina, Bot_Energia};
                for (int j = 0; j < 4; j++) begin
                    if (j == CH_TEST) continue;
                    while (expq[j].size() > 0 && expq[j][0] < cyc) begin
                        n_chk++; n_fail++;
                        $display("FAIL pulse_ch%0d missed: expected at cycle %0d, no pulse observed", j, expq[j][0]);
                        void'(expq[j].pop_front());
                    end
                    if (pv[j]) begin
                        n_chk++;
                        if (expq[j].size() == 0 || expq[j][0] != cyc) begin
                            n_fail++;
                            $display("FAIL pulse_ch%0d unexpected: seen at cycle %0d, next expected %0d",
                                     j, cyc, (expq[j].size() > 0) ? expq[j][0] : -1);
                        end else begin
                            void'(expq[j].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input int ch, input int n, input int after);
        raw[ch] = 1'b0;
        tick(n);
        raw[ch] = 1'b1;
        tick(after);
    endtask

    initial begin
        int rem[4];
        // 1. reset
        tick(5);
        @(negedge clk); #2 rst_n = 1'b1;
        tick(3);
        chk("post_reset_outputs", int'({estado_estable, Bot_Energia, Bot_Medicina, Bot_Test, Bot_Reset}), 0);

        // 2. clean energia press
        hold(CH_ENERGIA, 10, 12);

        // 3. medicina bouncing, then a real press
        repeat (6) begin raw[1] = ~raw[1]; tick(2); end
        hold(CH_MEDICINA, 8, 10);

        // 4. test: short press ignored, long presses toggle
        hold(CH_TEST, 8, 10);
        chk("test_short_ignored", int'(Bot_Test), 0);
        hold(CH_TEST, 30, 10);
        chk("test_long_toggle_1", int'(Bot_Test), 1);
        hold(CH_TEST, 30, 10);
        chk("test_long_toggle_0", int'(Bot_Test), 0);

        // 5. reset button, then a long hold with energia pressed concurrently
        hold(CH_RESET, 20, 10);
        raw[3] = 1'b0;
        tick(3);
        hold(CH_ENERGIA, 10, 87);
        raw[3] = 1'b1;
        tick(12);

        // 6. async reset during a long test hold
        raw[2] = 1'b0;
        tick(16);
        chk("test_held_stable", int'(estado_estable[2]), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", int'({estado_estable, Bot_Energia, Bot_Medicina, Bot_Test, Bot_Reset}), 0);
        tick(3);
        @(negedge clk); #2 rst_n = 1'b1;
        tick(30);
        chk("test_toggle_after_reset", int'(Bot_Test), 1);
        raw[2] = 1'b1;
        tick(10);

        // Random phase: mixes bounces, short and long holds, and occasional resets.
        for (int i = 0; i < 4; i++) rem[i] = 0;
        repeat (1500) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0) begin
                    raw[i] = ~raw[i];
                    rem[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(DEB, LARGO + 12);
                end else begin
                    rem[i]--;
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        raw = 4'hF;
        tick(LARGO + 20);
        for (int j = 0; j < 4; j++) chk("drain_queue", expq[j].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
